// File: rtl/mem_arbiter.sv
// Two-master (instr/data) arbiter onto one req/gnt/rvalid memory port; zero-latency request and response paths.
// Holds at most DEPTH outstanding requests; MEM_ARB_RR_EN selects round-robin, otherwise data has fixed priority.
module mem_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  output logic        data_gnt,
  output logic        data_rvalid,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        proto_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic             proto_err_q, proto_err_d;

  logic win_vld, win_id, push, pop, head, resp_vld, empty;

`ifdef MEM_ARB_RR_EN
  // 0 = instr granted last, 1 = data granted last
  logic last_q, last_d;
  assign win_id = (instr_req && data_req) ? ~last_q : data_req;
`else
  assign win_id = data_req;
`endif

  assign win_vld  = instr_req || data_req;
  assign empty    = (count_q == '0);
  assign head     = fifo_q[rd_ptr_q];

  assign mem_req  = !rst && win_vld && (count_q < CW'(DEPTH));
  assign push     = mem_req && mem_gnt;
  assign resp_vld = !rst && mem_rvalid && !empty;
  assign pop      = resp_vld;

  assign mem_we    = win_id ? data_we    : 1'b0;
  assign mem_be    = win_id ? data_be    : 4'hF;
  assign mem_addr  = win_id ? data_addr  : instr_addr;
  assign mem_wdata = win_id ? data_wdata : 32'h0;

  assign instr_gnt    = push && !win_id;
  assign data_gnt     = push &&  win_id;
  assign instr_rvalid = resp_vld && !head;
  assign data_rvalid  = resp_vld &&  head;
  assign instr_rdata  = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign instr_err    = instr_rvalid && mem_err;
  assign data_err     = data_rvalid && mem_err;
  assign proto_err    = proto_err_q;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_d      = fifo_q;
    proto_err_d = proto_err_q || (mem_rvalid && empty);
    if (push) begin
      fifo_d[wr_ptr_q] = win_id;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (push) last_d = win_id;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_q      <= fifo_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing a single simulation memory port (req/gnt/rvalid protocol) between the core's instruction fetch port and data port. It sits between the core and a unified memory model in the simulation top level. It forwards one granted request per cycle and tracks outstanding transactions in an in-order source FIFO, so each `rvalid`/`rdata`/`err` response is routed back to the master that issued it.

## Interface
Parameters:
- `DEPTH`, default 2: maximum outstanding accepted-but-unanswered transactions; power of two, ≥1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `instr_req`  in  1  instruction master request
- `instr_gnt`  out  1  instruction request accepted this cycle
- `instr_rvalid`  out  1  instruction response valid
- `instr_addr`  in  32  instruction byte address
- `instr_rdata`  out  32  instruction read data
- `instr_err`  out  1  instruction response error
- `data_req`  in  1  data master request
- `data_gnt`  out  1  data request accepted this cycle
- `data_rvalid`  out  1  data response valid
- `data_we`  in  1  write enable
- `data_be`  in  4  byte enables
- `data_addr`  in  32  data byte address
- `data_wdata`  in  32  write data
- `data_rdata`  out  32  data read data
- `data_err`  out  1  data response error
- `mem_req`, `mem_we`, `mem_be[3:0]`, `mem_addr[31:0]`, `mem_wdata[31:0]`  out  request to memory
- `mem_gnt`, `mem_rvalid`, `mem_rdata[31:0]`, `mem_err`  in  response from memory
- `proto_err`  out  1  sticky: `mem_rvalid` arrived with no outstanding transaction

## Operation
- Winner selection is combinational each cycle from `instr_req`/`data_req`; a lone requester always wins.
- Conflict (both requesting): resolved per Configuration.
- `mem_req` = (winner exists) && (count < DEPTH). Blocking at count == DEPTH applies even if a pop occurs the same cycle.
- `mem_*` request fields come from the winner; the instruction master drives `we=0`, `be=4'hF`, `wdata=0`.
- `X_gnt` = `mem_gnt` && `mem_req` && (winner == X); the loser's `gnt` is 0.
- Source FIFO: on `mem_req && mem_gnt`, push the winner id (0 = instr, 1 = data). On `mem_rvalid` with count > 0, pop the head.
- Simultaneous push and pop: count is unchanged and FIFO order is preserved.
- Response routing: `X_rvalid` = `mem_rvalid` && (count > 0) && (head == X).
- `mem_rdata` and `mem_err` are fanned out to both masters. `X_err` is qualified by `X_rvalid`.
- `mem_rvalid` with count == 0 is dropped (no `rvalid` to either master) and sets `proto_err`. It clears only on reset.
- Masters must hold `req` and request fields stable until `gnt`. The arbiter does not latch request fields.

## Timing
- Request path has zero added latency: `mem_req`/`gnt` are combinational.
- Response path has zero added latency: `rvalid`/`rdata` are combinational from `mem_*`.
- Throughput is one accepted request per cycle while count < DEPTH.
- Reset values: count = 0, FIFO pointers = 0, `proto_err` = 0, RR pointer = instr last-granted. All `gnt`/`rvalid` outputs = 0 while `rst` is high, and `mem_req` = 0 while `rst` is high.
- Reset mid-transaction: outstanding entries are discarded. A `mem_rvalid` arriving afterwards sets `proto_err`.
- Pointers wrap modulo DEPTH.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-granted register updates on every `mem_req && mem_gnt`.
  - On conflict, the master not granted last wins.
  - After reset, data wins the first conflict.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always beats instr. No last-granted register exists.

## Test plan
- Instr only: `instr_req=1`, addr `0x100`, memory answers 1 cycle later with `0x00000013` → `instr_gnt=1` same cycle, `instr_rvalid=1`, `instr_rdata=0x13` next cycle, `data_rvalid=0`.
- Conflict: both request for 4 cycles with `mem_gnt=1`.
  - RR build: grants alternate data, instr, data, instr.
  - Fixed build: data granted all 4 cycles and `instr_gnt=0`.
- Backpressure: DEPTH=2, memory withholds `rvalid` → 2 grants, then `mem_req=0` and `gnt=0` until the first `mem_rvalid`. At count == DEPTH with a pop in the same cycle, still no grant.
- Ordering: instr then data accepted back-to-back, responses `0xA` then `0xB` → `instr_rdata=0xA` on the first `rvalid`, `data_rdata=0xB` on the second.
- Error routing: data write with `be=4'b0011` answered with `mem_err=1` → `data_rvalid=1`, `data_err=1`, `instr_err=0`. `mem_be` equals `4'b0011` during the request.
- Spurious response: `mem_rvalid=1` with nothing outstanding → no master `rvalid`, `proto_err=1` and held. Asserting `rst` for 1 cycle → `proto_err=0`, count=0.
